// File: rtl/alu_bitserial_sequencer_if.sv
// Start/done bus of the bit-serial ALU sequencer: operands and control in,
// registered result and flags out.
interface alu_bitserial_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, alu_ctl,
    input  busy, done, result, zero, carry_out, overflow
  );

  modport slave (
    input  start, a, b, alu_ctl,
    output busy, done, result, zero, carry_out, overflow
  );
endinterface

// File: rtl/alu_bitserial_sequencer.sv
// Full WIDTH-bit ALU built from one time-shared 1-bit slice, LSB first.
// Owns the carry register, bit counter, result shift register and SLT fix-up.
module alu_bitserial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_bitserial_sequencer_if.slave bus,
  output logic [1:0]               state_dbg
);
  // Handshake: start is sampled only in IDLE; an accepted start latches a, b
  // and alu_ctl, busy covers RUN and DONE, and done pulses for one cycle when
  // result/zero/carry_out/overflow become valid. They hold until the next MSB step.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       ctl_l;
  logic             carry;

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             cout_bit;
  logic             slice_res;
  logic             set_bit;
  logic [WIDTH-1:0] final_res;

  assign state_dbg = state;

  // The 1-bit slice, fed from the latched operands at the current bit index.
  always_comb begin
    a_bit    = a_l[idx] ^ ctl_l[3];
    b_bit    = b_l[idx] ^ ctl_l[2];
    sum_bit  = a_bit ^ b_bit ^ carry;
    cout_bit = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    case (ctl_l[1:0])
      2'b00:   slice_res = a_bit & b_bit;
      2'b01:   slice_res = a_bit | b_bit;
      2'b10:   slice_res = sum_bit;
      default: slice_res = 1'b0;
    endcase
    set_bit   = (carry ^ cout_bit) ^ sum_bit;
    final_res = {slice_res, shreg[WIDTH-1:1]};
    if (ctl_l[1:0] == 2'b11) begin
      final_res = {{(WIDTH-1){1'b0}}, set_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      carry         <= 1'b0;
      a_l           <= '0;
      b_l           <= '0;
      ctl_l         <= '0;
      shreg         <= '0;
      bus.result    <= '0;
      bus.zero      <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_l      <= bus.a;
            b_l      <= bus.b;
            ctl_l    <= bus.alu_ctl;
            idx      <= '0;
            carry    <= bus.alu_ctl[2];
            shreg    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Bits shift in from the top so bit 0 lands at position 0 after WIDTH steps.
          shreg <= {slice_res, shreg[WIDTH-1:1]};
          carry <= cout_bit;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            idx           <= '0;
            bus.result    <= final_res;
            bus.zero      <= (final_res == '0);
            bus.carry_out <= ctl_l[1] & cout_bit;
            bus.overflow  <= (ctl_l[1:0] == 2'b10) & (carry ^ cout_bit);
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bitserial_sequencer.sv
// Directed bench for alu_bitserial_sequencer: ALU ops, handshake timing,
// start-while-busy, held start and mid-operation reset.
module tb_alu_bitserial_sequencer;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  alu_bitserial_sequencer_if #(.WIDTH(W)) bus();

  alu_bitserial_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for done; called at #1 after an edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full operation; entered and left at #1 after an edge with the DUT in IDLE.
  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res,
                       input logic z, input logic co, input logic ov);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(res);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.alu_ctl = ctl;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.alu_ctl = ~ctl;
    check({tag, "_busy_e0"}, 64'(bus.busy), 64'd1);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'd32);
    e = exp_q.pop_front();
    check({tag, "_result"}, 64'(bus.result), 64'(e));
    check({tag, "_zero"}, 64'(bus.zero), 64'(z));
    check({tag, "_cout"}, 64'(bus.carry_out), 64'(co));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(ov));
    @(posedge clk); #1;
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_done_end"}, 64'(bus.done), 64'd0);
    check({tag, "_held"}, 64'(bus.result), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcount;
    int first_hit;
    logic [W-1:0] saved;

    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_ctl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    check("rst_cout", 64'(bus.carry_out), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    do_op("sub_eq", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0);
    do_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    do_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    do_op("slt_ovf", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    do_op("slt_gt", 4'b0111, 32'd3, 32'd2, 32'd0, 1'b1, 1'b1, 1'b0);
    do_op("nor", 4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    do_op("and", 4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    do_op("or", 4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);

    // start pulsed mid-RUN with operands changed: only the original op completes
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd23; bus.alu_ctl = 4'b0010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcount = 0; saved = '0; first_hit = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; end
      if (n == 4) bus.start = 1'b1;
      if (n == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dcount++;
        if (dcount == 1) begin saved = bus.result; first_hit = n; end
      end
    end
    check("ign_done_count", 64'(dcount), 64'd1);
    check("ign_done_edge", 64'(first_hit), 64'd32);
    check("ign_result", 64'(saved), 64'd123);
    check("ign_idle", 64'(bus.busy), 64'd0);

    // start held high: re-accepted at E34
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.alu_ctl = 4'b0010;
    @(posedge clk); #1;
    first_hit = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (first_hit == 0 && n > 33 && bus.busy === 1'b1) begin
        first_hit = n;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("held_reaccept_edge", 64'(first_hit), 64'd34);
    wait_done(dcount);
    check("held_second_done", 64'(bus.done), 64'd1);
    check("held_result", 64'(bus.result), 64'd2);
    @(posedge clk); #1;

    // reset sampled at E10 of an ADD aborts it without a done pulse
    bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd8; bus.alu_ctl = 4'b0010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_zero", 64'(bus.zero), 64'd1);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    dcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    do_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_bitserial_sequencer.md
# alu_bitserial_sequencer

Multi-cycle controller that performs a full WIDTH-bit ALU operation by time-sharing a single 1-bit ALU slice, one bit per clock, LSB first. The slice provides Ainvert/Binvert input muxes, AND/OR/full-adder/Less result mux, and MSB overflow/set logic. The block owns the carry register, bit counter, result shift register and SLT fix-up. It sits in the datapath as an area-reduced ALU behind a start/done handshake.

## Interface
- WIDTH, 32, operand/result width; legal range 2..64.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- alu_ctl  in  4  {Ainvert, Binvert, Operation[1:0]}; latched when start is accepted. Examples: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; the result outputs are valid from this cycle onward.
- result  out  WIDTH  final result; held until the next accepted start.
- zero  out  1  result == 0.
- carry_out  out  1  carry out of the MSB, for Operation==10 or 11; 0 otherwise.
- overflow  out  1  MSB carry-in XOR MSB carry-out, for Operation==10 only; 0 otherwise.

## Operation
- States: IDLE, RUN, DONE.
- Any alu_ctl value is legal. The slice is driven generically from the latched ctl.
- IDLE, start=1:
  - latch a, b and alu_ctl;
  - set idx=0;
  - set carry register to Binvert;
  - clear the result shift register;
  - go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each cycle:
  - Slice inputs are a_l[idx], b_l[idx], carry, Less=0, with the latched Ainvert/Binvert/Operation.
  - The slice result bit is written to result bit idx.
  - carry is loaded with the slice carry-out.
  - idx increments.
- RUN at idx==WIDTH-1 (MSB step):
  - Capture msb_cin (the carry before the step) and msb_cout.
  - overflow = msb_cin ^ msb_cout when Operation==10, else 0.
  - set = (msb_cin ^ msb_cout) ^ sum_msb.
  - carry_out = msb_cout when Operation[1]==1, else 0.
  - When Operation==11, result = {WIDTH-1 zeros, set}. All bits are 0 during RUN (Less=0), so only bit 0 is replaced.
  - Go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - start is ignored.
  - Next state is IDLE.
- start is ignored while busy. Changes on a, b or alu_ctl after acceptance have no effect.
- zero is derived from the final registered result. It is 1 at reset, because result resets to 0.
- Overflow/set is always computed at the MSB, whatever WIDTH is.

## Timing
- Reset values:
  - state=IDLE, idx=0, carry=0;
  - result=0, zero=1;
  - busy=0, done=0, carry_out=0, overflow=0.
- reset wins over every other event. Asserted mid-RUN or in DONE, it aborts the operation and forces the reset values at the next edge. No done pulse is produced.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy goes high after E0;
  - edges E1..E_WIDTH process bits 0..WIDTH-1;
  - done is high in the cycle after E_WIDTH;
  - busy falls after E_WIDTH+1.
- Latency: done follows start acceptance by WIDTH edges. Throughput is one operation per WIDTH+2 cycles.
- The earliest next start is the cycle after done, when the block is in IDLE. A start held continuously high is therefore re-accepted at E_WIDTH+2.
- result, zero, carry_out and overflow are updated only by the MSB step and by reset. They are stable between done and the next MSB step. Partial result bits are internal only and not visible on result.

## Test plan
- ADD (0010), a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, carry_out=0, zero=0. done is high exactly after the 32nd edge following E0, and busy spans 33 edges.
- SUB (0110), a=5, b=5 -> result=0, zero=1, carry_out=1, overflow=0. Also SUB 0x80000000-1 -> 0x7FFFFFFF with overflow=1.
- SLT (0111), three cases:
  - a=0xFFFFFFFF, b=1 -> result=1;
  - a=0x80000000, b=1 (overflow case) -> result=1, overflow=0;
  - a=3, b=2 -> result=0, zero=1.
- Logic ops, a=0x0F0F0F0F, b=0x00FF00FF:
  - NOR (1100) -> 0xF000F000, carry_out=0;
  - AND -> 0x000F000F;
  - OR -> 0x0FFF0FFF.
- start pulsed at E5 during RUN, with a/b changed at E3 -> ignored; a single done arrives with the original-operand result. Start held high continuously -> the second acceptance occurs at E34.
- reset asserted at E10 of an ADD -> the next cycle shows busy=0, result=0, zero=1, and no done pulse. A new ADD 2+3 then completes normally with result=5.
